usb_tx_stuff_nrzi: RTL and testbench
====================================

// Module: usb_tx_stuff_nrzi
// PURPOSE
//  Transmit-side line encoder for the USB TX path; counterpart to the RX bit-unstuffer/NRZI decoder.
//  Takes a serial bit stream from the TX shift logic over a ready/valid handshake.
//  Inserts a 0 after every six consecutive 1s, NRZI-encodes, then drives D+/D-.
//  Appends EOP (2 bit-times SE0, 1 bit-time J) after the last bit.
// PARAMETERS
//  CLKS_PER_BIT  8  clk cycles per USB bit time (>=2)
//  MAX_ONES      6  consecutive 1s that force a stuffed 0
// PORTS
//  clk         in   1  system clock, all logic on rising edge
//  n_rst       in   1  asynchronous, active-low reset
//  tx_valid    in   1  tx_bit/tx_last valid
//  tx_bit      in   1  next data bit (LSB-first order done upstream)
//  tx_last     in   1  marks final data bit of packet
//  bit_ready   out  1  bit accepted this cycle when bit_ready && tx_valid
//  dplus_out   out  1  D+ line
//  dminus_out  out  1  D- line
//  tx_busy     out  1  high whenever state != IDLE
//  tx_done     out  1  1-cycle pulse on return to IDLE after EOP
//  tx_error    out  1  1-cycle pulse on underrun (tx_valid low when a bit is due)
// BEHAVIOUR
//  Reset: state IDLE; dplus_out=1, dminus_out=0 (J); NRZI level=J; ones count=0.
//   tx_busy, tx_done, tx_error = 0. bit_ready=1 (combinational, IDLE).
//  Reset asserted mid-packet forces J and IDLE immediately; no tx_done, no tx_error.
//  Bit timer: 0..CLKS_PER_BIT-1 while state != IDLE; tick = timer at CLKS_PER_BIT-1.
//   Every line level holds exactly CLKS_PER_BIT cycles.
//  NRZI rule:
//   Data 0 (incl. stuffed 0) toggles the line (J<->K).
//   Data 1 holds the line.
//   The line updates on the cycle after the bit is accepted (1-cycle latency).
//  Ones count:
//   +1 on an accepted 1; cleared on any 0, stuffed or data; saturates at MAX_ONES.
//  States:
//   IDLE:
//    bit_ready=1. On tx_valid: accept the bit -> DATA, timer=0.
//   DATA, at tick, in priority order:
//    ones==MAX_ONES -> STUFF (drive a 0; bit_ready stays low).
//    else cur_last -> EOP_SE0.
//    else tx_valid -> accept the next bit (bit_ready=1 on the tick cycle only); stay in DATA.
//    else -> tx_error pulse -> EOP_SE0.
//    bit_ready=0 on all non-tick cycles.
//   STUFF, at tick:
//    cur_last -> EOP_SE0. Stuffing after the final bit is mandatory.
//    else accept the next bit -> DATA, or underrun -> error -> EOP_SE0.
//   EOP_SE0: D+=D-=0 for 2 bit times -> EOP_J.
//   EOP_J: J for 1 bit time; at tick -> IDLE, tx_done pulse, NRZI level=J, ones=0.
//   bit_ready=0 in STUFF/EOP_*.
//  Simultaneous events:
//   tx_last accepted with ones reaching MAX_ONES -> STUFF, then EOP.
//   Underrun wins only when no stuff is due.
//  dplus_out/dminus_out are registered (no combinational path from inputs).
//  Never SE0 outside EOP.
// STRUCTURE
//  usb_tx_pkg:
//   typedef enum {IDLE,DATA,STUFF,EOP_SE0,EOP_J} tx_state_t
//   localparams LINE_J=2'b10, LINE_K=2'b01, LINE_SE0=2'b00 ({D+,D-})
//  Sub-module: reuse existing flex_counter as the bit timer.
//   rollover_val=CLKS_PER_BIT, clear on IDLE entry.
//   count_enable = state != IDLE.
//  Ones count and EOP bit count are small inline counters.
// TESTING
//  Reset: n_rst=0 -> D+=1, D-=0, tx_busy=0, bit_ready=1.
//   Release: no line change without tx_valid.
//  SYNC 8'h80 LSB-first, tx_last on bit 7:
//   line K,J,K,J,K,J,K,K, each 8 clk.
//   Then SE0 16 clk, J 8 clk, tx_done pulse once.
//  Bits 0 then 1x7:
//   line K, holds K 6 bit times, stuffed toggle to J.
//   7th 1 holds J; bit_ready low for the stuff bit time.
//  Packet ending on 6th consecutive 1: stuffed bit emitted, then SE0,SE0,J; tx_done.
//  Underrun: drop tx_valid before a tick mid-packet -> tx_error 1 clk, then full EOP, tx_done.
//  Reset mid-stuff-bit: n_rst=0 -> J in same cycle.
//   Next packet starts from J with ones=0.

Source files
------------

// File: rtl/usb_tx_pkg.sv
// Shared types and line encodings for the USB transmit line encoder.
// Line values are packed as {D+, D-}.
package usb_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DATA,
    STUFF,
    EOP_SE0,
    EOP_J
  } tx_state_t;

  localparam logic [1:0] LINE_J   = 2'b10;
  localparam logic [1:0] LINE_K   = 2'b01;
  localparam logic [1:0] LINE_SE0 = 2'b00;

  // NRZI: a 0 flips the differential level, a 1 holds it.
  function automatic logic [1:0] nrzi_next(input logic [1:0] level, input logic data_bit);
    logic [1:0] nxt;
    if (data_bit) nxt = level;
    else          nxt = (level == LINE_J) ? LINE_K : LINE_J;
    return nxt;
  endfunction

endpackage

// File: rtl/usb_tx_stuff_nrzi_if.sv
// Serial bit handshake between the TX shift logic (master) and the line encoder (slave).
interface usb_tx_stuff_nrzi_if;
    logic tx_valid;
    logic tx_bit;
    logic tx_last;
    logic bit_ready;

    modport master (output tx_valid, output tx_bit, output tx_last, input bit_ready);
    modport slave  (input tx_valid, input tx_bit, input tx_last, output bit_ready);
endinterface

// File: rtl/flex_counter.sv
// Generic up-counter: counts 0..rollover_val-1 while enabled, then wraps to 0.
// Synchronous clear has priority over counting.
module flex_counter #(
    parameter int NUM_CNT_BITS = 4
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    clear,
    input  logic                    count_enable,
    input  logic [NUM_CNT_BITS-1:0] rollover_val,
    output logic [NUM_CNT_BITS-1:0] count_out
);

    logic [NUM_CNT_BITS-1:0] last_val;

    assign last_val = rollover_val - NUM_CNT_BITS'(1);

    // NOTE: sequential state is written with <= only, so every flop samples
    // the pre-edge value of every other flop regardless of statement order.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count_out <= '0;
        end else if (clear) begin
            count_out <= '0;
        end else if (count_enable) begin
            if (count_out == last_val) count_out <= '0;
            else                       count_out <= count_out + NUM_CNT_BITS'(1);
        end
    end

endmodule

// File: rtl/usb_tx_stuff_nrzi.sv
// USB TX line encoder: bit stuffing after MAX_ONES consecutive 1s, NRZI encoding,
// and EOP generation (2 bit-times SE0, 1 bit-time J) onto registered D+/D-.
module usb_tx_stuff_nrzi
    import usb_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 8,
    parameter int MAX_ONES     = 6
) (
    input  logic                      clk,
    input  logic                      n_rst,
    usb_tx_stuff_nrzi_if.slave        tx,
    output logic                      dplus_out,
    output logic                      dminus_out,
    output logic                      tx_busy,
    output logic                      tx_done,
    output logic                      tx_error
);

    localparam int TIMER_W = $clog2(CLKS_PER_BIT + 1);
    localparam int ONES_W  = $clog2(MAX_ONES + 1);

    tx_state_t           state;
    logic [TIMER_W-1:0]  timer;
    logic                tick;
    logic [ONES_W-1:0]   ones_cnt;
    logic                stuff_due;
    logic                cur_last;
    logic                eop_cnt;
    logic [1:0]          nrzi_level;
    logic [1:0]          line;
    logic                bit_ready;
    logic                accept;

    flex_counter #(
        .NUM_CNT_BITS (TIMER_W)
    ) u_bit_timer (
        .clk          (clk),
        .n_rst        (n_rst),
        .clear        (state == IDLE),
        .count_enable (state != IDLE),
        .rollover_val (TIMER_W'(CLKS_PER_BIT)),
        .count_out    (timer)
    );

    assign tick      = (state != IDLE) && (timer == TIMER_W'(CLKS_PER_BIT - 1));
    assign stuff_due = (ones_cnt == ONES_W'(MAX_ONES));

    // Ready is decoded only from registered state, never from tx_valid.
    // NOTE: every output of an always_comb gets a default first, so no path
    // through the case can leave it unassigned and infer a latch.
    always_comb begin
        bit_ready = 1'b0;
        case (state)
            IDLE:    bit_ready = 1'b1;
            DATA:    bit_ready = tick && !stuff_due && !cur_last;
            STUFF:   bit_ready = tick && !cur_last;
            default: bit_ready = 1'b0;
        endcase
    end

    assign tx.bit_ready = bit_ready;
    assign accept       = bit_ready && tx.tx_valid;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state      <= IDLE;
            line       <= LINE_J;
            nrzi_level <= LINE_J;
            ones_cnt   <= '0;
            cur_last   <= 1'b0;
            eop_cnt    <= 1'b0;
            tx_done    <= 1'b0;
            tx_error   <= 1'b0;
        end else begin
            tx_done  <= 1'b0;
            tx_error <= 1'b0;

            if (accept) begin
                state      <= DATA;
                cur_last   <= tx.tx_last;
                nrzi_level <= nrzi_next(nrzi_level, tx.tx_bit);
                line       <= nrzi_next(nrzi_level, tx.tx_bit);
                if (!tx.tx_bit)     ones_cnt <= '0;
                else if (!stuff_due) ones_cnt <= ones_cnt + ONES_W'(1);
            end

            // Accepting branches are handled above; these cover the other tick outcomes.
            case (state)
                DATA: begin
                    if (tick) begin
                        if (stuff_due) begin
                            state      <= STUFF;
                            ones_cnt   <= '0;
                            nrzi_level <= nrzi_next(nrzi_level, 1'b0);
                            line       <= nrzi_next(nrzi_level, 1'b0);
                        end else if (cur_last || !tx.tx_valid) begin
                            tx_error <= !cur_last;
                            state    <= EOP_SE0;
                            line     <= LINE_SE0;
                            eop_cnt  <= 1'b0;
                        end
                    end
                end
                STUFF: begin
                    if (tick && (cur_last || !tx.tx_valid)) begin
                        tx_error <= !cur_last;
                        state    <= EOP_SE0;
                        line     <= LINE_SE0;
                        eop_cnt  <= 1'b0;
                    end
                end
                EOP_SE0: begin
                    if (tick) begin
                        if (eop_cnt) begin
                            state   <= EOP_J;
                            line    <= LINE_J;
                            eop_cnt <= 1'b0;
                        end else begin
                            eop_cnt <= 1'b1;
                        end
                    end
                end
                EOP_J: begin
                    if (tick) begin
                        state      <= IDLE;
                        tx_done    <= 1'b1;
                        nrzi_level <= LINE_J;
                        ones_cnt   <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign dplus_out  = line[1];
    assign dminus_out = line[0];
    assign tx_busy    = (state != IDLE);

endmodule

// File: tb/tb_usb_tx_stuff_nrzi.sv
// Directed bench for usb_tx_stuff_nrzi: table of packets with hand-computed line
// sequences (one char per bit time: J, K, S=SE0), plus reset and abort sequences.
module tb_usb_tx_stuff_nrzi;
    import usb_tx_pkg::*;

    localparam int CPB = 8;

    logic clk = 1'b0;
    logic n_rst = 1'b1;
    logic dplus, dminus, tx_busy, tx_done, tx_error;

    always #5 clk = ~clk;

    usb_tx_stuff_nrzi_if bus();

    usb_tx_stuff_nrzi #(
        .CLKS_PER_BIT (CPB),
        .MAX_ONES     (6)
    ) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .tx         (bus),
        .dplus_out  (dplus),
        .dminus_out (dminus),
        .tx_busy    (tx_busy),
        .tx_done    (tx_done),
        .tx_error   (tx_error)
    );

    typedef struct {
        string       name;
        logic [31:0] bits;         // bit 0 is sent first
        int          nbits;
        int          underrun_at;  // index of the bit withheld, -1 for none
        string       exp_line;
        int          exp_err;
        int          exp_ready;    // ready-high cycles between first accept and tx_done
    } vec_t;

    vec_t vecs[8];

    int n_tests = 0;
    int n_fail  = 0;

    string    got_line;
    int       got_err, got_done, got_ready_hi, busy_errs;
    logic     ready_q[$];
    logic [1:0] line_q[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic check_s(input string name, input string got, input string exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got \"%s\" expected \"%s\"", name, got, exp);
        end
    endtask

    function automatic string sym(input logic [1:0] s);
        string r;
        case (s)
            LINE_J:   r = "J";
            LINE_K:   r = "K";
            LINE_SE0: r = "S";
            default:  r = "X";
        endcase
        return r;
    endfunction

    // Drives one packet, sampling and driving on the falling edge, and records the
    // line from the cycle after the first accept up to (not including) tx_done.
    task automatic run_packet(input logic [31:0] bits, input int nbits,
                              input int underrun_at, input int abort_at);
        int   idx = 0;
        int   rec = 0;
        logic fire = 1'b0;
        logic started = 1'b0;
        logic txv;
        logic [1:0] s;
        logic same;
        line_q.delete();
        ready_q.delete();
        got_err = 0; got_done = 0; got_ready_hi = 0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            @(negedge clk);
            if (fire) idx++;
            if (started) begin
                if (tx_error) got_err++;
                if (tx_done) begin
                    got_done++;
                    if (tx_busy) busy_errs++;
                    break;
                end
                if (abort_at >= 0 && rec == abort_at) begin
                    check("abort pre line", {30'd0, dplus, dminus}, {30'd0, LINE_K});
                    n_rst = 1'b0;
                    #1;
                    check("abort line J", {30'd0, dplus, dminus}, {30'd0, LINE_J});
                    check("abort busy", {31'd0, tx_busy}, 32'd0);
                    bus.tx_valid = 1'b0;
                    return;
                end
                if (!tx_busy) busy_errs++;
                line_q.push_back({dplus, dminus});
                ready_q.push_back(bus.bit_ready);
                if (bus.bit_ready) got_ready_hi++;
                rec++;
            end
            txv = (idx < nbits) && (underrun_at < 0 || idx < underrun_at);
            bus.tx_valid = txv;
            bus.tx_bit   = (idx < 32) ? bits[idx] : 1'b0;
            bus.tx_last  = (idx == nbits - 1);
            fire = txv && bus.bit_ready;
            if (fire) started = 1'b1;
        end
        bus.tx_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (tx_done) got_done++;
        end
        got_line = "";
        for (int g = 0; g < line_q.size() / CPB; g++) begin
            s = line_q[g*CPB];
            same = 1'b1;
            for (int j = 1; j < CPB; j++)
                if (line_q[g*CPB + j] !== s) same = 1'b0;
            if (same) got_line = {got_line, sym(s)};
            else      got_line = {got_line, "?"};
        end
        if (line_q.size() % CPB != 0) got_line = {got_line, "?"};
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int bad;
        logic [7:0] pat;

        vecs[0] = '{"sync",        32'h80,  8, -1, "KJKJKJKKSSJ",       0, 7};
        vecs[1] = '{"zero_1x7",    32'hFE,  8, -1, "KKKKKKKJJSSJ",      0, 7};
        vecs[2] = '{"end_on_6th",  32'h7E,  7, -1, "KKKKKKKJSSJ",       0, 6};
        vecs[3] = '{"underrun",    32'h02,  6,  3, "KKJSSJ",            1, 3};
        vecs[4] = '{"ones_x12",    32'hFFF, 12, -1, "JJJJJJKKKKKKKJSSJ", 0, 11};
        vecs[5] = '{"single_one",  32'h01,  1, -1, "JSSJ",              0, 0};
        vecs[6] = '{"single_zero", 32'h00,  1, -1, "KSSJ",              0, 0};
        vecs[7] = '{"underrun_stf",32'h3F,  8,  6, "JJJJJJKSSJ",        1, 6};

        bus.tx_valid = 1'b0;
        bus.tx_bit   = 1'b0;
        bus.tx_last  = 1'b0;
        busy_errs    = 0;

        // Reset state
        #2 n_rst = 1'b0;
        #20;
        check("reset dplus",  {31'd0, dplus},         32'd1);
        check("reset dminus", {31'd0, dminus},        32'd0);
        check("reset busy",   {31'd0, tx_busy},       32'd0);
        check("reset ready",  {31'd0, bus.bit_ready}, 32'd1);
        check("reset done",   {31'd0, tx_done},       32'd0);
        check("reset error",  {31'd0, tx_error},      32'd0);
        @(negedge clk);
        n_rst = 1'b1;

        // No line activity without tx_valid
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if ({dplus, dminus} !== LINE_J || tx_busy !== 1'b0) bad++;
        end
        check("idle hold", bad, 0);

        for (int v = 0; v < 8; v++) begin
            run_packet(vecs[v].bits, vecs[v].nbits, vecs[v].underrun_at, -1);
            check_s({vecs[v].name, " line"}, got_line, vecs[v].exp_line);
            check({vecs[v].name, " error"}, got_err, vecs[v].exp_err);
            check({vecs[v].name, " done"}, got_done, 1);
            check({vecs[v].name, " ready"}, got_ready_hi, vecs[v].exp_ready);
            if (v == 1) begin
                pat = 8'h00;
                if (ready_q.size() >= 8*CPB)
                    for (int j = 0; j < CPB; j++) pat[j] = ready_q[7*CPB + j];
                check("stuff ready pattern", {24'd0, pat}, 32'h80);
            end
        end
        check("busy window", busy_errs, 0);

        // Reset in the middle of a stuffed bit (seven 1s: stuff bit time is K)
        run_packet(32'h7F, 7, -1, 6*CPB + 3);
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (tx_done || tx_error || {dplus, dminus} !== LINE_J) bad++;
        end
        check("abort quiet", bad, 0);
        n_rst = 1'b1;
        run_packet(32'h3F, 6, -1, -1);
        check_s("post abort line", got_line, "JJJJJJKSSJ");
        check("post abort done", got_done, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
